// File: rtl/sdcard_cmd_responder.sv
// Card-side SD CMD line endpoint: oversamples sd_clk, decodes 48-bit host commands, and returns R1/R3/R6/R7 or R2 responses.
// Response start bit follows NCR sd_clk cycles after the command end bit; rsp_valid is held off until WAIT_RSP (rsp_ready), dropped after RSP_TIMEOUT rises.
module sdcard_cmd_responder #(
    parameter int NCR         = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sd_clk,
    input  logic         sd_cmd_IN,
    output logic         sd_cmd_OUT,
    output logic         sd_cmd_OE,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_err,
    input  logic         rsp_valid,
    output logic         rsp_ready,
    input  logic [1:0]   rsp_type,
    input  logic [5:0]   rsp_index,
    input  logic [127:0] rsp_data,
    output logic         rsp_timeout,
    output logic         busy
);

    localparam int NW = $clog2(NCR + 1);
    localparam int TW = $clog2(RSP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, NCR_WAIT, TX} state_t;
    state_t state_q, state_d;

    logic          sclk_s1, sclk_s2, sclk_d, cmd_s1, cmd_s2;
    logic          rise, fall, armed;
    logic [47:0]   rx_sr, frame_next;
    logic [5:0]    rx_cnt;
    logic          last_bit, frame_ok;
    logic [NW-1:0] ncr_cnt;
    logic          ncr_done;
    logic [TW-1:0] to_cnt;
    logic          to_hit, hs;
    logic [135:0]  tx_sr, tx_load;
    logic [7:0]    tx_cnt, tx_len, tx_len_load;
    logic          tx_shift, tx_end;
    logic [39:0]   r1_head;
    logic          unused_rsp_bit;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign rise       = sclk_s2 & ~sclk_d;
    assign fall       = ~sclk_s2 & sclk_d;
    assign frame_next = {rx_sr[46:0], cmd_s2};
    assign last_bit   = (rx_cnt == 6'd47);
    assign frame_ok   = frame_next[46] & frame_next[0] &
                        (crc7(frame_next[47:8]) == frame_next[7:1]);
    assign ncr_done   = (ncr_cnt == NW'(NCR));
    assign to_hit     = rise && (to_cnt == TW'(RSP_TIMEOUT - 1));
    assign hs         = (state_q == WAIT_RSP) && rsp_valid;
    assign tx_shift   = fall && (((state_q == NCR_WAIT) && ncr_done) ||
                                 ((state_q == TX) && (tx_cnt != tx_len)));
    assign tx_end     = fall && (state_q == TX) && (tx_cnt == tx_len);
    assign rsp_ready  = (state_q == WAIT_RSP);
    assign busy       = (state_q != IDLE);
    assign r1_head    = {2'b00, rsp_index, rsp_data[31:0]};
    assign unused_rsp_bit = rsp_data[0];

    // Response frames are left-aligned so the MSB is always the next bit on the wire.
    always_comb begin
        tx_load     = '0;
        tx_len_load = 8'd48;
        case (rsp_type)
            2'd1: tx_load = {r1_head, crc7(r1_head), 1'b1, 88'b0};
            2'd2: tx_load = {2'b00, 6'h3F, rsp_data[31:0], 7'h7F, 1'b1, 88'b0};
            2'd3: begin
                tx_load     = {2'b00, 6'h3F, rsp_data[127:1], 1'b1};
                tx_len_load = 8'd136;
            end
            default: tx_load = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rise && armed && !cmd_s2) state_d = RX;
            RX:       if (rise && last_bit) state_d = frame_ok ? WAIT_RSP : IDLE;
            WAIT_RSP: begin
                if (hs)          state_d = (rsp_type == 2'd0) ? IDLE : NCR_WAIT;
                else if (to_hit) state_d = IDLE;
            end
            NCR_WAIT: if (fall && ncr_done) state_d = TX;
            TX:       if (tx_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_d      <= 1'b0;
            cmd_s1      <= 1'b1;
            cmd_s2      <= 1'b1;
            armed       <= 1'b0;
            rx_sr       <= '0;
            rx_cnt      <= '0;
            ncr_cnt     <= '0;
            to_cnt      <= '0;
            tx_sr       <= '0;
            tx_cnt      <= '0;
            tx_len      <= 8'd48;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_index   <= '0;
            cmd_arg     <= '0;
            sd_cmd_OE   <= 1'b0;
            sd_cmd_OUT  <= 1'b1;
        end else begin
            sclk_s1     <= sd_clk;
            sclk_s2     <= sclk_s1;
            sclk_d      <= sclk_s2;
            cmd_s1      <= sd_cmd_IN;
            cmd_s2      <= cmd_s1;
            // First rise after reset may come from a stale synchronizer value.
            armed       <= armed | rise;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            case (state_q)
                IDLE: if (rise && armed && !cmd_s2) begin
                    rx_sr  <= '0;
                    rx_cnt <= 6'd1;
                end
                RX: if (rise) begin
                    rx_sr  <= frame_next;
                    rx_cnt <= rx_cnt + 6'd1;
                    if (last_bit) begin
                        if (frame_ok) begin
                            cmd_valid <= 1'b1;
                            cmd_index <= frame_next[45:40];
                            cmd_arg   <= frame_next[39:8];
                            ncr_cnt   <= '0;
                            to_cnt    <= '0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rise && !ncr_done) ncr_cnt <= ncr_cnt + NW'(1);
                    if (rise) to_cnt <= to_cnt + TW'(1);
                    if (hs) begin
                        tx_sr  <= tx_load;
                        tx_len <= tx_len_load;
                        tx_cnt <= '0;
                    end else if (to_hit) begin
                        rsp_timeout <= 1'b1;
                    end
                end
                NCR_WAIT: if (rise && !ncr_done) ncr_cnt <= ncr_cnt + NW'(1);
                default: ;
            endcase

            if (tx_shift) begin
                sd_cmd_OUT <= tx_sr[135];
                sd_cmd_OE  <= 1'b1;
                tx_sr      <= {tx_sr[134:0], 1'b0};
                tx_cnt     <= tx_cnt + 8'd1;
            end else if (tx_end) begin
                sd_cmd_OE  <= 1'b0;
                sd_cmd_OUT <= 1'b1;
            end
        end
    end

endmodule
